// File: rtl/iic_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module  : iic_slave_pkg
// Brief   : Shared types and constants for the iic_slave_regs I2C target.
// Revision: 1.0 - initial release
// ============================================================================
package iic_slave_pkg;

    localparam logic [2:0] BIT_LAST    = 3'd7;
    localparam int         SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEV     = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_ADDR_LO = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_WAIT    = 3'd6
    } state_e;

    // Position inside a 9-bit byte slot: data bits, our ACK, or the master's ACK.
    typedef enum logic [1:0] {
        PH_DATA = 2'd0,
        PH_ACK  = 2'd1,
        PH_MACK = 2'd2
    } phase_e;

endpackage
`default_nettype wire

// File: rtl/iic_slave_regs_sync.sv
`default_nettype none
// ============================================================================
// Module  : iic_bus_sync
// Brief   : SCL/SDA synchronizers, SCL edge detect and START/STOP detect.
// Revision: 1.0 - initial release
// ============================================================================
module iic_bus_sync
    import iic_slave_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);

    logic [SYNC_STAGES-1:0] r_scl_sync_q;
    logic [SYNC_STAGES-1:0] r_sda_sync_q;
    logic                   r_scl_hist_q;
    logic                   r_sda_hist_q;
    logic                   w_scl_s;
    logic                   w_sda_s;

    // Idle bus is high, so reset to 1 to avoid phantom edges after reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_scl_sync_q <= '1;
            r_sda_sync_q <= '1;
            r_scl_hist_q <= 1'b1;
            r_sda_hist_q <= 1'b1;
        end else begin
            r_scl_sync_q <= {r_scl_sync_q[SYNC_STAGES-2:0], i_scl};
            r_sda_sync_q <= {r_sda_sync_q[SYNC_STAGES-2:0], i_sda};
            r_scl_hist_q <= w_scl_s;
            r_sda_hist_q <= w_sda_s;
        end
    end

    assign w_scl_s    = r_scl_sync_q[SYNC_STAGES-1];
    assign w_sda_s    = r_sda_sync_q[SYNC_STAGES-1];
    assign o_sda      = w_sda_s;
    assign o_scl_rise = w_scl_s & ~r_scl_hist_q;
    assign o_scl_fall = ~w_scl_s & r_scl_hist_q;
    assign o_start    = w_scl_s & r_scl_hist_q & ~w_sda_s & r_sda_hist_q;
    assign o_stop     = w_scl_s & r_scl_hist_q & w_sda_s & ~r_sda_hist_q;

endmodule
`default_nettype wire

// File: rtl/iic_slave_regs.sv
`default_nettype none
// ============================================================================
// Module  : iic_slave_regs
// Brief   : I2C target for 16-bit address / 8-bit data register access.
// Revision: 1.0 - initial release
// ============================================================================
module iic_slave_regs
    import iic_slave_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h59,
    parameter int         ADDR_BYTE = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        iic_scl,
    input  logic        sda_in,
    output logic        sda_out_en,
    output logic [15:0] reg_addr,
    output logic        reg_wr,
    output logic [7:0]  reg_wdata,
    output logic        reg_rd,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    logic        w_scl_rise;
    logic        w_scl_fall;
    logic        w_start;
    logic        w_stop;
    logic        w_sda_s;

    state_e      r_state_q,   w_state_d;
    phase_e      r_phase_q,   w_phase_d;
    logic [2:0]  r_bit_cnt_q, w_bit_cnt_d;
    logic [7:0]  r_shift_q,   w_shift_d;
    logic        r_sda_oe_q,  w_sda_oe_d;
    logic [15:0] r_addr_q,    w_addr_d;
    logic        r_wr_q,      w_wr_d;
    logic [7:0]  r_wdata_q,   w_wdata_d;
    logic        r_rd_q,      w_rd_d;
    logic        r_busy_q,    w_busy_d;
    logic [7:0]  w_byte;
    logic        w_dev_match;

    iic_bus_sync u_sync (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .i_scl      (iic_scl),
        .i_sda      (sda_in),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_sda      (w_sda_s)
    );

    assign w_byte      = {r_shift_q[6:0], w_sda_s};
    assign w_dev_match = (w_byte[7:1] == DEV_ADDR);

    always_comb begin
        w_state_d   = r_state_q;
        w_phase_d   = r_phase_q;
        w_bit_cnt_d = r_bit_cnt_q;
        w_shift_d   = r_shift_q;
        w_sda_oe_d  = r_sda_oe_q;
        w_addr_d    = r_addr_q;
        w_wr_d      = 1'b0;
        w_wdata_d   = r_wdata_q;
        w_rd_d      = 1'b0;
        w_busy_d    = r_busy_q;

        // Post-strobe bookkeeping: advance pointer, load read data.
        if (r_wr_q) begin
            w_addr_d = r_addr_q + 16'd1;
        end
        if (r_rd_q) begin
            w_shift_d = reg_rdata;
            w_addr_d  = r_addr_q + 16'd1;
        end

        if (w_stop) begin
            w_state_d   = ST_IDLE;
            w_phase_d   = PH_DATA;
            w_bit_cnt_d = 3'd0;
            w_sda_oe_d  = 1'b0;
            w_busy_d    = 1'b0;
        end else if (w_start) begin
            w_state_d   = ST_DEV;
            w_phase_d   = PH_DATA;
            w_bit_cnt_d = 3'd0;
            w_sda_oe_d  = 1'b0;
        end else begin
            case (r_state_q)
                ST_DEV, ST_ADDR_HI, ST_ADDR_LO, ST_WR_DATA: begin
                    if (r_phase_q == PH_ACK) begin
                        if (w_scl_fall) begin
                            w_sda_oe_d = 1'b1;
                        end else if (w_scl_rise) begin
                            w_phase_d = PH_DATA;
                        end
                    end else if (w_scl_fall) begin
                        w_sda_oe_d = 1'b0;
                    end else if (w_scl_rise) begin
                        w_shift_d = w_byte;
                        if (r_bit_cnt_q == BIT_LAST) begin
                            w_bit_cnt_d = 3'd0;
                            w_phase_d   = PH_ACK;
                            case (r_state_q)
                                ST_DEV: begin
                                    if (!w_dev_match) begin
                                        w_state_d = ST_WAIT;
                                        w_phase_d = PH_DATA;
                                    end else begin
                                        w_busy_d = 1'b1;
                                        if (w_byte[0]) begin
                                            w_rd_d    = 1'b1;
                                            w_state_d = ST_RD_DATA;
                                        end else begin
                                            w_state_d = (ADDR_BYTE == 2) ? ST_ADDR_HI : ST_ADDR_LO;
                                        end
                                    end
                                end
                                ST_ADDR_HI: begin
                                    w_addr_d[15:8] = w_byte;
                                    w_state_d      = ST_ADDR_LO;
                                end
                                ST_ADDR_LO: begin
                                    w_addr_d[7:0] = w_byte;
                                    w_state_d     = ST_WR_DATA;
                                end
                                default: begin
                                    w_wr_d    = 1'b1;
                                    w_wdata_d = w_byte;
                                end
                            endcase
                        end else begin
                            w_bit_cnt_d = r_bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_RD_DATA: begin
                    case (r_phase_q)
                        PH_ACK: begin
                            if (w_scl_fall) begin
                                w_sda_oe_d = 1'b1;
                            end else if (w_scl_rise) begin
                                w_phase_d = PH_DATA;
                            end
                        end
                        PH_DATA: begin
                            // Open drain: a 0 bit pulls the line, a 1 bit releases it.
                            if (w_scl_fall) begin
                                w_sda_oe_d = ~r_shift_q[7];
                                w_shift_d  = {r_shift_q[6:0], 1'b0};
                            end else if (w_scl_rise) begin
                                if (r_bit_cnt_q == BIT_LAST) begin
                                    w_bit_cnt_d = 3'd0;
                                    w_phase_d   = PH_MACK;
                                end else begin
                                    w_bit_cnt_d = r_bit_cnt_q + 3'd1;
                                end
                            end
                        end
                        default: begin
                            if (w_scl_fall) begin
                                w_sda_oe_d = 1'b0;
                            end else if (w_scl_rise) begin
                                w_phase_d = PH_DATA;
                                if (w_sda_s) begin
                                    w_state_d = ST_WAIT;
                                end else begin
                                    w_rd_d = 1'b1;
                                end
                            end
                        end
                    endcase
                end
                default: begin
                    w_sda_oe_d = 1'b0;
                end
            endcase
        end

        if (ADDR_BYTE == 1) begin
            w_addr_d[15:8] = 8'h00;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state_q   <= ST_IDLE;
            r_phase_q   <= PH_DATA;
            r_bit_cnt_q <= 3'd0;
            r_shift_q   <= 8'h00;
            r_sda_oe_q  <= 1'b0;
            r_addr_q    <= 16'h0000;
            r_wr_q      <= 1'b0;
            r_wdata_q   <= 8'h00;
            r_rd_q      <= 1'b0;
            r_busy_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_phase_q   <= w_phase_d;
            r_bit_cnt_q <= w_bit_cnt_d;
            r_shift_q   <= w_shift_d;
            r_sda_oe_q  <= w_sda_oe_d;
            r_addr_q    <= w_addr_d;
            r_wr_q      <= w_wr_d;
            r_wdata_q   <= w_wdata_d;
            r_rd_q      <= w_rd_d;
            r_busy_q    <= w_busy_d;
        end
    end

    assign sda_out_en = r_sda_oe_q;
    assign reg_addr   = r_addr_q;
    assign reg_wr     = r_wr_q;
    assign reg_wdata  = r_wdata_q;
    assign reg_rd     = r_rd_q;
    assign busy       = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_iic_slave_regs.sv
`default_nettype none
// ============================================================================
// Module  : tb_iic_slave_regs
// Brief   : Bus-level master driving iic_slave_regs, checked against a memory model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_iic_slave_regs;
    import iic_slave_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_out_en;
    logic [15:0] reg_addr;
    logic        reg_wr;
    logic [7:0]  reg_wdata;
    logic        reg_rd;
    logic [7:0]  reg_rdata = 8'h00;
    logic        busy;

    iic_slave_regs dut (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .iic_scl    (scl),
        .sda_in     (sda_bus),
        .sda_out_en (sda_out_en),
        .reg_addr   (reg_addr),
        .reg_wr     (reg_wr),
        .reg_wdata  (reg_wdata),
        .reg_rd     (reg_rd),
        .reg_rdata  (reg_rdata),
        .busy       (busy)
    );

    assign sda_bus = sda_m & ~sda_out_en;
    always #10 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          q = 10;
    logic [15:0] ptr = 16'h0000;
    logic [7:0]  model_mem [0:65535];
    logic [7:0]  wbuf [0:7];
    logic [15:0] force_a = 16'h0012;
    logic [7:0]  force_v = 8'hA5;

    // Register-file emulation on the DUT side of the port.
    logic [7:0]  rf [0:65535];
    bit          rf_wr [0:65535];
    logic [15:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    logic [15:0] rd_addr_q [$];
    int          oe_cnt = 0;
    int          both_cnt = 0;

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
            rf[reg_addr]    = reg_wdata;
            rf_wr[reg_addr] = 1'b1;
        end
        if (reg_rd) begin
            rd_addr_q.push_back(reg_addr);
            if (reg_addr == force_a)    reg_rdata = force_v;
            else if (rf_wr[reg_addr])   reg_rdata = rf[reg_addr];
            else                        reg_rdata = dflt(reg_addr);
        end
        if (reg_wr && reg_rd) both_cnt++;
        if (sda_out_en) oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start;
        sda_m = 1'b1; tick(q);
        scl   = 1'b1; tick(q);
        sda_m = 1'b0; tick(q);
        scl   = 1'b0; tick(q);
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; tick(q);
        scl   = 1'b1; tick(q);
        sda_m = 1'b1; tick(q);
    endtask

    task automatic bus_bit(input bit b, output bit s);
        sda_m = b;    tick(q);
        scl   = 1'b1; tick(q);
        s = sda_bus;  tick(q);
        scl   = 1'b0; tick(q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input bit mack, output logic [7:0] d);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(~mack, s);
    endtask

    task automatic do_write(input logic [6:0] dev, input logic [15:0] a, input int n, input string tag);
        bit          ack;
        bit          m;
        logic [15:0] p;
        int          w0;
        m  = (dev == 7'h59);
        w0 = wr_addr_q.size();
        bus_start;
        wr_byte({dev, 1'b0}, ack); check({tag, "_ack_dev"}, 32'(ack), 32'(m));
        check({tag, "_busy"}, 32'(busy), 32'(m));
        wr_byte(a[15:8], ack);     check({tag, "_ack_hi"}, 32'(ack), 32'(m));
        wr_byte(a[7:0], ack);      check({tag, "_ack_lo"}, 32'(ack), 32'(m));
        for (int i = 0; i < n; i++) begin
            wr_byte(wbuf[i], ack); check({tag, "_ack_data"}, 32'(ack), 32'(m));
        end
        bus_stop;
        if (m) begin
            p = a;
            for (int i = 0; i < n; i++) begin
                model_mem[p] = wbuf[i];
                p = p + 16'd1;
            end
            ptr = p;
        end
        check({tag, "_wr_count"}, 32'(wr_addr_q.size() - w0), m ? 32'(n) : 32'd0);
        p = a;
        for (int i = 0; i < n; i++) begin
            if (m && (w0 + i) < wr_addr_q.size()) begin
                check({tag, "_wr_addr"}, 32'(wr_addr_q[w0+i]), 32'(p));
                check({tag, "_wr_data"}, 32'(wr_data_q[w0+i]), 32'(wbuf[i]));
            end
            p = p + 16'd1;
        end
        check({tag, "_ptr"}, 32'(reg_addr), 32'(ptr));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic do_read(input logic [15:0] a, input int n, input string tag);
        bit          ack;
        logic [7:0]  d;
        logic [15:0] p;
        int          r0;
        r0 = rd_addr_q.size();
        bus_start;
        wr_byte(8'hB2, ack);   check({tag, "_ack_dev_w"}, 32'(ack), 32'd1);
        wr_byte(a[15:8], ack); check({tag, "_ack_hi"}, 32'(ack), 32'd1);
        wr_byte(a[7:0], ack);  check({tag, "_ack_lo"}, 32'(ack), 32'd1);
        bus_start;
        wr_byte(8'hB3, ack);   check({tag, "_ack_dev_r"}, 32'(ack), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        p = a;
        for (int i = 0; i < n; i++) begin
            rd_byte(i != n - 1, d);
            check({tag, "_data"}, 32'(d), 32'(model_mem[p]));
            p = p + 16'd1;
        end
        bus_stop;
        ptr = p;
        check({tag, "_rd_count"}, 32'(rd_addr_q.size() - r0), 32'(n));
        p = a;
        for (int i = 0; i < n; i++) begin
            if ((r0 + i) < rd_addr_q.size())
                check({tag, "_rd_addr"}, 32'(rd_addr_q[r0+i]), 32'(p));
            p = p + 16'd1;
        end
        check({tag, "_ptr"}, 32'(reg_addr), 32'(ptr));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_idle"}, 32'(dut.r_state_q), 32'(ST_IDLE));
    endtask

    initial begin
        bit          ack;
        bit          s;
        int          o0;
        int          w0;
        int          kind;
        int          n;
        logic [15:0] a;

        for (int i = 0; i < 65536; i++) model_mem[i] = dflt(16'(i));

        tick(4);
        check("rst_oe",    32'(sda_out_en), 32'd0);
        check("rst_addr",  32'(reg_addr),   32'd0);
        check("rst_wr",    32'(reg_wr),     32'd0);
        check("rst_wdata", 32'(reg_wdata),  32'd0);
        check("rst_rd",    32'(reg_rd),     32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_state", 32'(dut.r_state_q), 32'(ST_IDLE));
        rst = 1'b0;
        tick(5);

        // Single write at 100 kHz SCL.
        q = 125;
        wbuf[0] = 8'h34;
        do_write(7'h59, 16'h0012, 1, "wr100k");
        q = 10;

        // Random read of 0x0012 returning 0xA5.
        model_mem[16'h0012] = 8'hA5;
        do_read(16'h0012, 1, "rdA5");

        // Wrong device address: no ACK, line never pulled.
        o0 = oe_cnt;
        wbuf[0] = 8'h55;
        do_write(7'h50, 16'h0001, 1, "miss");
        check("miss_oe_quiet", 32'(oe_cnt - o0), 32'd0);

        // Burst across the address wrap.
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        do_write(7'h59, 16'hFFFF, 2, "wrap");

        // STOP after four data bits of a write.
        w0 = wr_addr_q.size();
        bus_start;
        wr_byte(8'hB2, ack); check("part_ack_dev", 32'(ack), 32'd1);
        wr_byte(8'h00, ack); check("part_ack_hi",  32'(ack), 32'd1);
        wr_byte(8'h40, ack); check("part_ack_lo",  32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom), s);
        bus_stop;
        ptr = 16'h0040;
        check("part_no_wr", 32'(wr_addr_q.size() - w0), 32'd0);
        check("part_idle",  32'(dut.r_state_q), 32'(ST_IDLE));
        check("part_busy",  32'(busy), 32'd0);
        check("part_ptr",   32'(reg_addr), 32'(ptr));
        wbuf[0] = 8'($urandom);
        do_write(7'h59, 16'h0041, 1, "after_part");

        // Randomized mix of writes, reads and foreign-address traffic.
        for (int t = 0; t < 8; t++) begin
            kind = int'($urandom_range(0, 2));
            a    = 16'($urandom_range(32'h0100, 32'hFEFF));
            n    = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            case (kind)
                0:       do_write(7'h59, a, n, "rnd_wr");
                1:       do_read(a, n, "rnd_rd");
                default: do_write(7'h59 ^ 7'($urandom_range(1, 127)), a, n, "rnd_miss");
            endcase
        end

        // Reset while the target is driving a 0 data bit.
        force_a = 16'h4321;
        force_v = 8'h00;
        model_mem[16'h4321] = 8'h00;
        bus_start;
        wr_byte(8'hB2, ack); check("rr_ack_dev_w", 32'(ack), 32'd1);
        wr_byte(8'h43, ack); check("rr_ack_hi",    32'(ack), 32'd1);
        wr_byte(8'h21, ack); check("rr_ack_lo",    32'(ack), 32'd1);
        bus_start;
        wr_byte(8'hB3, ack); check("rr_ack_dev_r", 32'(ack), 32'd1);
        check("rr_driving0", 32'(sda_out_en), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rr_oe",    32'(sda_out_en), 32'd0);
        check("rr_addr",  32'(reg_addr),   32'd0);
        check("rr_wr",    32'(reg_wr),     32'd0);
        check("rr_wdata", 32'(reg_wdata),  32'd0);
        check("rr_rd",    32'(reg_rd),     32'd0);
        check("rr_busy",  32'(busy),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        ptr = 16'h0000;
        tick(3);
        bus_stop;
        wbuf[0] = 8'h5C;
        do_write(7'h59, 16'h2000, 1, "post_rst");

        check("never_wr_and_rd", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
